// File: rtl/cam_pe_pkg.sv
// cam_pe_pkg: shared helpers for the cam_pe CAM.
//   idx_w/cnt_w : derived index and occupancy-counter widths for a given depth
//   res_w       : width of the packed registered search result
//   RES_*       : bit layout of the packed result {idx, learned, multi, hit}
package cam_pe_pkg;

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned RES_HIT_BIT   = 0;
  localparam int unsigned RES_MULTI_BIT = 1;
  localparam int unsigned RES_LEARN_BIT = 2;
  localparam int unsigned RES_IDX_LSB   = 3;

  function automatic int unsigned res_w(input int unsigned iw);
    return RES_IDX_LSB + iw;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// cam_prio_enc: lowest-index priority encoder with multi-hit detection.
//   vec_i   : request vector
//   any_o   : at least one bit set
//   multi_o : two or more bits set
//   idx_o   : index of the lowest set bit (0 when none)
module cam_prio_enc
  import cam_pe_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic          any_o,
  output logic          multi_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    any_o   = 1'b0;
    multi_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        if (!any_o) idx_o = IW'(i);
        else        multi_o = 1'b1;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_pe.sv
// cam_pe: parametrised CAM with per-entry valid bits, lowest-index match,
// multi-hit flag, occupancy count and optional learn-on-miss.
//   clk, rst_n           : clock, async active-low reset
//   srch_en/srch_key     : search request; learn_en inserts the key on a miss
//   wr_en/wr_idx/wr_key  : direct write (sets valid)
//   inv_en/inv_idx       : invalidate one entry; clr_all invalidates all
//   res_*                : registered search result, one cycle after srch_en
//   count/full/empty     : occupancy
module cam_pe
  import cam_pe_pkg::*;
#(
  parameter int unsigned KEY_W = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = idx_w(DEPTH),
  parameter int unsigned CNT_W = cnt_w(DEPTH),
  parameter int unsigned LEARN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srch_en,
  input  logic [KEY_W-1:0] srch_key,
  input  logic             learn_en,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx,
  input  logic             clr_all,
  output logic             res_valid,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_multi,
  output logic             res_learned,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned RW = res_w(IDX_W);

  logic [KEY_W-1:0] key_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] match, inv_mask, free_vec;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RW-1:0]    res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             m_any, m_multi, f_any, f_multi_unused;
  logic [IDX_W-1:0] m_idx, f_idx;
  logic             wr_ok, inv_ok, learn;

  // Out-of-range indices (non-power-of-2 DEPTH) turn the operation into a no-op.
  assign wr_ok  = wr_en  && (32'(wr_idx)  < DEPTH);
  assign inv_ok = inv_en && (32'(inv_idx) < DEPTH);

  always_comb begin
    match    = '0;
    inv_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i]    = valid_q[i] && (key_q[i] == srch_key);
      inv_mask[i] = inv_ok && (32'(inv_idx) == i);
    end
  end

  // The entry being invalidated this cycle is not offered as a free slot.
  assign free_vec = ~valid_q & ~inv_mask;

  cam_prio_enc #(.N(DEPTH), .IW(IDX_W)) u_match_enc (
    .vec_i   (match),
    .any_o   (m_any),
    .multi_o (m_multi),
    .idx_o   (m_idx)
  );

  cam_prio_enc #(.N(DEPTH), .IW(IDX_W)) u_free_enc (
    .vec_i   (free_vec),
    .any_o   (f_any),
    .multi_o (f_multi_unused),
    .idx_o   (f_idx)
  );

  assign learn = (LEARN != 0) && srch_en && learn_en && !m_any && !full &&
                 !wr_en && !clr_all && f_any;

  // Later assignments win: write overrides invalidate on the same index.
  always_comb begin
    valid_d = valid_q;
    if (clr_all) begin
      valid_d = '0;
    end else begin
      if (learn)  valid_d[f_idx]   = 1'b1;
      if (inv_ok) valid_d[inv_idx] = 1'b0;
      if (wr_ok)  valid_d[wr_idx]  = 1'b1;
    end
  end

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_d[i]) count_d = count_d + CNT_W'(1);
    end
  end

  always_comb begin
    res_valid_d = srch_en;
    res_d       = '0;
    if (srch_en) begin
      res_d[RES_HIT_BIT]   = m_any;
      res_d[RES_MULTI_BIT] = m_multi;
      res_d[RES_LEARN_BIT] = learn;
      if (learn)      res_d[RES_IDX_LSB +: IDX_W] = f_idx;
      else if (m_any) res_d[RES_IDX_LSB +: IDX_W] = m_idx;
    end
  end

  // Key storage carries no reset; only valid bits define occupancy.
  always_ff @(posedge clk) begin
    if (!clr_all) begin
      if (wr_ok)      key_q[wr_idx] <= wr_key;
      else if (learn) key_q[f_idx]  <= srch_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_hit     = res_q[RES_HIT_BIT];
  assign res_multi   = res_q[RES_MULTI_BIT];
  assign res_learned = res_q[RES_LEARN_BIT];
  assign res_idx     = res_q[RES_IDX_LSB +: IDX_W];
  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);

endmodule

// File: tb/tb_cam_pe.sv
// tb_cam_pe: randomized + directed bench for cam_pe with a behavioural model
// and a scoreboard queue consumed by an independent monitor.
module tb_cam_pe;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       srch_en = 1'b0, learn_en = 1'b0, wr_en = 1'b0, inv_en = 1'b0, clr_all = 1'b0;
  logic [7:0] srch_key = '0, wr_key = '0;
  logic [3:0] wr_idx = '0, inv_idx = '0;
  logic       res_valid, res_hit, res_multi, res_learned, full, empty;
  logic [3:0] res_idx;
  logic [4:0] count;

  cam_pe #(.KEY_W(8), .DEPTH(DEPTH), .LEARN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .srch_en(srch_en), .srch_key(srch_key), .learn_en(learn_en),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .inv_en(inv_en), .inv_idx(inv_idx), .clr_all(clr_all),
    .res_valid(res_valid), .res_hit(res_hit), .res_idx(res_idx),
    .res_multi(res_multi), .res_learned(res_learned),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vld, hit, multi, learned;
    int idx, cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain arrays of stored keys and valid flags.
  int m_key [DEPTH];
  bit m_val [DEPTH];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_val[i];
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive one cycle of stimulus, predict, advance.
  task automatic step(input bit s, input int key, input bit ln,
                      input bit w, input int wi, input int wk,
                      input bit iv, input int ii, input bit c);
    exp_t e;
    int   hits, first, fr;
    bit   lok;
    srch_en = s; srch_key = 8'(key); learn_en = ln;
    wr_en = w; wr_idx = 4'(wi); wr_key = 8'(wk);
    inv_en = iv; inv_idx = 4'(ii); clr_all = c;

    hits = 0; first = -1; fr = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_val[i] && m_key[i] == key) begin
        if (first < 0) first = i;
        hits++;
      end
      if (fr < 0 && !m_val[i] && !(iv && ii == i)) fr = i;
    end
    lok = s && ln && hits == 0 && m_count() != DEPTH && !w && !c && fr >= 0;
    e.vld = s;
    e.hit = s && hits > 0;
    e.multi = s && hits > 1;
    e.learned = lok;
    e.idx = lok ? fr : (e.hit ? first : 0);

    if (c) begin
      for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    end else begin
      if (lok) begin m_val[fr] = 1; m_key[fr] = key; end
      if (iv) m_val[ii] = 0;
      if (w)  begin m_val[wi] = 1; m_key[wi] = wk; end
    end
    e.cnt = m_count();
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic srch(input int key, input bit ln);
    step(1, key, ln, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int wi, input int wk);
    step(0, 0, 0, 1, wi, wk, 0, 0, 0);
  endtask

  task automatic clr();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: one expectation per cycle, sampled 1 time unit after posedge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("res_valid", int'(res_valid), int'(e.vld));
        chk("res_hit", int'(res_hit), int'(e.hit));
        chk("res_idx", int'(res_idx), e.idx);
        chk("res_multi", int'(res_multi), int'(e.multi));
        chk("res_learned", int'(res_learned), int'(e.learned));
        chk("count", int'(count), e.cnt);
        chk("full", int'(full), int'(e.cnt == DEPTH));
        chk("empty", int'(empty), int'(e.cnt == 0));
      end
    end
  end

  initial begin : stim
    exp_t z;
    for (int i = 0; i < DEPTH; i++) begin m_val[i] = 0; m_key[i] = 0; end
    z = '{vld: 0, hit: 0, multi: 0, learned: 0, idx: 0, cnt: 0};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: empty CAM search
    srch(8'h00, 0);
    // 2: duplicate key, lowest index and multi-hit
    wr(3, 8'hA5);
    wr(9, 8'hA5);
    srch(8'hA5, 0);
    // 3: learn-on-miss allocates lowest free slot
    clr();
    wr(0, 8'h01); wr(1, 8'h02); wr(2, 8'h03);
    srch(8'h3C, 1);
    srch(8'h3C, 0);
    // 4: learn blocked when full
    for (int i = 0; i < DEPTH; i++) wr(i, 8'h40 + i);
    srch(8'h77, 1);
    srch(8'h4F, 1);
    // 5: write beats invalidate; search reads pre-update state
    clr();
    step(1, 8'h11, 0, 1, 5, 8'h11, 1, 5, 0);
    srch(8'h11, 0);
    // learn with wr_en in same cycle is blocked; inv target not a free slot
    step(1, 8'h22, 1, 1, 7, 8'h33, 0, 0, 0);
    step(1, 8'h44, 1, 0, 0, 0, 1, 0, 0);
    srch(8'h44, 0);
    // 6: clr_all suppresses a same-cycle write
    step(0, 0, 0, 1, 2, 8'h99, 0, 0, 1);
    srch(8'h99, 0);

    // Reset arrives while a search is being issued; its result must not appear.
    wr(4, 8'h55);
    srch_en = 1'b1; srch_key = 8'h55; learn_en = 1'b0;
    wr_en = 1'b0; inv_en = 1'b0; clr_all = 1'b0;
    #1 rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    q.push_back(z);
    @(negedge clk);
    srch_en = 1'b0;
    rst_n = 1'b1;
    q.push_back(z);
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    srch(8'h55, 0);

    // Randomized traffic over a small key space to force hits and duplicates.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1), $urandom_range(0, 7),
           $urandom_range(0, 4) == 0, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 79) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_pe.md
Name: cam_pe

Overview:
Parametrised content-addressable memory with per-entry valid bits, a lowest-index priority encoder, multi-hit detection, occupancy tracking and an optional learn-on-miss mode.
- A search key is compared against all valid entries in parallel.
- The result is registered and returned one cycle later.
- It is the generalised successor of the 16x8 lookup CAM, used for tag/ID lookup in the datapath.

Parameters:
- KEY_W, 8, key/data width in bits (>=1)
- DEPTH, 16, number of entries (>=2)
- IDX_W, $clog2(DEPTH), index width (derived, do not override)
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)
- LEARN, 1, 1 = learn-on-miss logic present; 0 = learn_en ignored and res_learned tied to 0

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- srch_en  in  1  search request this cycle
- srch_key  in  KEY_W  key to look up
- learn_en  in  1  qualifies srch_en: on a miss, insert srch_key into the lowest free entry
- wr_en  in  1  direct write
- wr_idx  in  IDX_W  write entry index
- wr_key  in  KEY_W  write key
- inv_en  in  1  invalidate one entry
- inv_idx  in  IDX_W  entry to invalidate
- clr_all  in  1  invalidate all entries
- res_valid  out  1  result strobe, one cycle after srch_en
- res_hit  out  1  at least one valid entry matched
- res_idx  out  IDX_W  lowest matching index; on a learn, the allocated index; else 0
- res_multi  out  1  two or more valid entries matched
- res_learned  out  1  key was inserted by learn-on-miss
- count  out  CNT_W  number of valid entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
Reset values:
- Async reset clears all valid bits.
- Key storage need not be reset.
- Outputs: res_* = 0, count = 0, full = 0, empty = 1.

Matching and latency:
- match[i] = valid[i] && key[i] == srch_key. Invalid entries never match, whatever they store.
- Search sampled at edge N: res_valid = 1 for exactly the cycle after edge N, with the res_* fields.
- res_valid = 0 in cycles without a preceding srch_en; the other res_* fields then hold 0.
- Back-to-back searches give one result per cycle; no stall and no handshake.

Update priority per cycle (highest first):
- clr_all: all valid bits 0; wr, inv and learn are suppressed this cycle.
- wr_en: key[wr_idx] = wr_key, valid[wr_idx] = 1.
- inv_en: valid[inv_idx] = 0, unless inv_idx == wr_idx with wr_en set, in which case the write wins.
- learn: applies only if LEARN=1, srch_en && learn_en, no match, !full, and no wr_en or clr_all in the same cycle.
  - Allocates the lowest-index invalid entry and sets res_learned = 1 with res_idx = that index.
  - Otherwise res_learned = 0.
  - A learn blocked by full or wr_en returns res_hit = 0, res_learned = 0, res_idx = 0.

Same-cycle search and update:
- A search compares against state before that cycle's updates (read-before-write). A search and a write of the same key in one cycle gives a miss.
- Learn free-slot selection uses pre-update valid bits, but treats the entry being invalidated by inv_en as still occupied.

Occupancy:
- count tracks the popcount of valid after each edge.
- Writing an already-valid entry does not change count. Invalidating an invalid entry does not change count.
- full and empty are derived combinationally from count.

Widths and boundaries:
- Indices >= DEPTH (non-power-of-2 DEPTH) make wr and inv no-ops.
- count saturates naturally at DEPTH; no wrap is possible.
- Reset asserted mid-search suppresses the pending result: res_valid = 0 after reset release until a new srch_en.

Decomposition:
- Package cam_pe_pkg holds the derived-width helper functions (clog2-based IDX_W and CNT_W) and the result field layout constants.
- One sub-module, cam_prio_enc:
  - Parameter N.
  - Input: match vector.
  - Outputs: any, multi, lowest-set index.
  - Instantiated twice: once on match for the result, once on ~valid for free-slot selection.

Test Plan:
1. Reset, then srch_en with key 8'h00 and no entries written -> res_valid=1, res_hit=0, count=0, empty=1.
2. Write 8'hA5 to idx 3 and idx 9, then search 8'hA5 -> res_hit=1, res_idx=3, res_multi=1, count=2.
3. LEARN=1: search 8'h3C with learn_en, valid at idx 0..2 -> res_learned=1, res_idx=3, count increments. Searching 8'h3C again -> res_hit=1, res_idx=3.
4. Fill all 16 entries, then learn-miss 8'h77 -> full=1, res_hit=0, res_learned=0, count stays 16.
5. Same cycle: wr_en idx 5 key 8'h11, inv_en idx 5, srch 8'h11 -> this search misses, entry 5 ends up valid. The next search of 8'h11 gives res_idx=5.
6. clr_all together with wr_en -> count=0, empty=1, and the written key is not findable. Assert rst_n low the cycle after srch_en -> res_valid stays 0.
